// File: rtl/ms_serial_rx.sv
// Serial-mouse receive half of the emulated COM port: 16x oversampled UART RX into a small FIFO.
// Latency: 2 clk sync + <=1 tick start jitter; FIFO write one clk after the stop-bit vote.
// Backpressure: none on the line; a character arriving with the FIFO full is dropped and flags overrun_err.
module ms_serial_rx #(
  parameter int CLKFREQ    = 50_000_000,
  parameter int BAUD       = 1200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  input  logic                          wlen,
  input  logic                          rd_strobe,
  input  logic                          err_clr,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          framing_err,
  output logic                          overrun_err,
  output logic                          busy
);

  localparam int TICK = CLKFREQ / (BAUD * 16);
  localparam int TW   = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [TW-1:0] tcnt;
  logic          tick;
  logic          rx_meta, rxs;
  logic [1:0]    state;
  logic [3:0]    sc;
  logic [2:0]    bc;
  logic [1:0]    samp;      // samples taken at sc==7 (bit 1) and sc==8 (bit 0)
  logic [7:0]    sh;
  logic          w8;
  logic          got_bit;   // a data bit has been voted in the current bit window
  logic          vote;
  logic          last_bit;
  logic          push_pend;
  logic [7:0]    push_dat;
  logic          frame_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          empty, full, pop_ok, push_ok, ovf;

  assign tick     = (tcnt == TW'(TICK - 1));
  assign vote     = (samp[1] & samp[0]) | (samp[1] & rxs) | (samp[0] & rxs);
  assign last_bit = w8 ? (bc == 3'd7) : (bc == 3'd6);
  assign busy     = (state != S_IDLE);

  // Free-running oversample tick generator, wraps 0..TICK-1.
  always_ff @(posedge clk) begin
    if (reset)     tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + TW'(1);
  end

  // Two-flop synchronizer on the asynchronous line; idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  // Receive FSM: start-glitch rejection, 3-sample majority per bit, stop-bit check.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      sc        <= 4'd0;
      bc        <= 3'd0;
      samp      <= 2'b11;
      sh        <= 8'h00;
      w8        <= 1'b0;
      got_bit   <= 1'b0;
      push_pend <= 1'b0;
      push_dat  <= 8'h00;
      frame_set <= 1'b0;
    end else begin
      push_pend <= 1'b0;
      frame_set <= 1'b0;
      if (tick) begin
        samp <= {samp[0], rxs};
        sc   <= sc + 4'd1;
        case (state)
          S_IDLE: begin
            if (!rxs) begin
              state <= S_START;
              sc    <= 4'd0;
            end
          end
          S_START: begin
            if (sc == 4'd9) begin
              if (!vote) begin
                state   <= S_DATA;
                bc      <= 3'd0;
                w8      <= wlen;
                got_bit <= 1'b0;
              end else begin
                state <= S_IDLE;
              end
            end
          end
          S_DATA: begin
            if (sc == 4'd9) begin
              sh      <= {vote, sh[7:1]};
              got_bit <= 1'b1;
            end
            // The tail of the start-bit window also passes sc==15; only count
            // windows that actually carried a data bit.
            if (sc == 4'd15 && got_bit) begin
              got_bit <= 1'b0;
              if (last_bit) state <= S_STOP;
              else          bc    <= bc + 3'd1;
            end
          end
          S_STOP: begin
            // Leave at the vote so a following start edge is never missed.
            if (sc == 4'd9) begin
              state <= S_IDLE;
              if (vote) begin
                push_pend <= 1'b1;
                push_dat  <= w8 ? sh : {1'b0, sh[7:1]};
              end else begin
                frame_set <= 1'b1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_count = wptr - rptr;
  assign empty    = (wptr == rptr);
  assign full     = (rx_count == (AW+1)'(FIFO_DEPTH));
  assign pop_ok   = rd_strobe & ~empty;
  assign push_ok  = push_pend & (~full | pop_ok);
  assign ovf      = push_pend & full & ~pop_ok;
  assign rx_valid = ~empty;
  assign rx_data  = empty ? 8'h00 : mem[rptr[AW-1:0]];

  // FIFO storage; contents are qualified by the pointers so need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= push_dat;
  end

  // FIFO pointers, one bit wider than the index for full/empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_ONE;
      if (pop_ok)  rptr <= rptr + PTR_ONE;
    end
  end

  // Sticky error flags; a set in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (frame_set)    framing_err <= 1'b1;
      else if (err_clr) framing_err <= 1'b0;
      if (ovf)          overrun_err <= 1'b1;
      else if (err_clr) overrun_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ms_serial_rx.sv
// Directed bench for ms_serial_rx: frames driven bit by bit, results checked against hand-computed values.
// Latency: frames take 16*TICK clk per bit; checks are taken on the falling clock edge.
// Backpressure: exercises FIFO-full overrun and the pop-on-push-cycle case.
module tb_ms_serial_rx;

  // Line rate scaled up so the whole run stays short; still 16 ticks per bit.
  localparam int CLKFREQ = 1_920_000;
  localparam int BAUD    = 12_000;
  localparam int TICK    = CLKFREQ / (BAUD * 16);
  localparam int BIT     = 16 * TICK;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       wlen = 1'b0;
  logic       rd_strobe = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       framing_err;
  logic       overrun_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  ms_serial_rx #(.CLKFREQ(CLKFREQ), .BAUD(BAUD), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .wlen(wlen), .rd_strobe(rd_strobe),
    .err_clr(err_clr), .rx_data(rx_data), .rx_valid(rx_valid), .rx_count(rx_count),
    .framing_err(framing_err), .overrun_err(overrun_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_bits(input int n);
    repeat (n * BIT) @(negedge clk);
  endtask

  task automatic send_char(input logic [7:0] d, input int nbits, input logic stopv, input int nstop);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rxd = d[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = stopv;
    repeat (BIT) @(negedge clk);
    for (int i = 1; i < nstop; i++) begin
      rxd = 1'b1;
      repeat (BIT) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic pop();
    rd_strobe = 1'b1;
    @(negedge clk);
    rd_strobe = 1'b0;
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  logic [7:0] pkt [3];
  logic [7:0] exp7;
  logic       ok;

  initial begin
    pkt[0] = 8'h60; pkt[1] = 8'h85; pkt[2] = 8'h81;

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_count", rx_count, 3'd0);
    chk("rst_ferr", framing_err, 1'b0);
    chk("rst_oerr", overrun_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    idle_bits(1);

    // 7-bit 'M'
    wlen = 1'b0;
    send_char(8'h4D, 7, 1'b1, 1);
    idle_bits(1);
    chk("m_data", rx_data, 8'h4D);
    chk("m_count", rx_count, 3'd1);
    chk("m_ferr", framing_err, 1'b0);
    chk("m_oerr", overrun_err, 1'b0);
    pop();
    chk("m_empty", rx_valid, 1'b0);

    // Mouse packet, 7-bit characters, 2 stop bits back-to-back.
    // Only bits 6..0 go on the wire, so 0x85 arrives as 0x05 and 0x81 as 0x01.
    for (int i = 0; i < 3; i++) send_char(pkt[i], 7, 1'b1, 2);
    idle_bits(1);
    chk("pkt_count", rx_count, 3'd3);
    for (int i = 0; i < 3; i++) begin
      exp7 = pkt[i] & 8'h7F;
      chk($sformatf("pkt_data%0d", i), rx_data, exp7);
      pop();
    end
    chk("pkt_empty", rx_valid, 1'b0);

    // Four-tick low glitch on idle line
    rxd = 1'b0;
    repeat (4 * TICK) @(negedge clk);
    rxd = 1'b1;
    idle_bits(2);
    chk("gl_busy", busy, 1'b0);
    chk("gl_count", rx_count, 3'd0);
    chk("gl_ferr", framing_err, 1'b0);

    // 8-bit 0xA5 with stop bit low
    wlen = 1'b1;
    send_char(8'hA5, 8, 1'b0, 1);
    idle_bits(2);
    chk("fe_count", rx_count, 3'd0);
    chk("fe_ferr", framing_err, 1'b1);
    clr_err();
    chk("fe_clr", framing_err, 1'b0);

    // Five bytes without popping: fifth is dropped
    for (int i = 0; i < 5; i++) send_char(8'h11 + 8'(i), 8, 1'b1, 1);
    idle_bits(1);
    chk("ov_count", rx_count, 3'd4);
    chk("ov_oerr", overrun_err, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ov_data%0d", i), rx_data, 8'h11 + 8'(i));
      pop();
    end
    chk("ov_empty", rx_valid, 1'b0);
    clr_err();
    chk("ov_clr", overrun_err, 1'b0);

    // Same again, popping on the push cycle of the fifth byte
    for (int i = 0; i < 4; i++) send_char(8'h11 + 8'(i), 8, 1'b1, 1);
    idle_bits(1);
    chk("pp_full", rx_count, 3'd4);
    fork
      send_char(8'h15, 8, 1'b1, 1);
      begin
        // Push lands on the edge after busy falls; strobe exactly that edge.
        ok = 1'b0;
        for (int n = 0; n < 4 * BIT && !ok; n++) begin
          @(negedge clk);
          if (busy) ok = 1'b1;
        end
        chk("pp_busy_rise", ok, 1'b1);
        ok = 1'b0;
        for (int n = 0; n < 16 * BIT && !ok; n++) begin
          @(negedge clk);
          if (!busy) ok = 1'b1;
        end
        chk("pp_busy_fall", ok, 1'b1);
        pop();
      end
    join
    idle_bits(1);
    chk("pp_oerr", overrun_err, 1'b0);
    chk("pp_count", rx_count, 3'd4);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("pp_data%0d", i), rx_data, 8'h12 + 8'(i));
      pop();
    end
    chk("pp_last", rx_data, 8'h15);
    chk("pp_count1", rx_count, 3'd1);

    // Reset mid-DATA of 0x3C, held until the line is idle, then a clean 0x42
    fork
      send_char(8'h3C, 8, 1'b1, 1);
      begin
        repeat (3 * BIT + BIT / 2) @(negedge clk);
        chk("mr_busy_pre", busy, 1'b1);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("mr_busy", busy, 1'b0);
        chk("mr_valid", rx_valid, 1'b0);
        chk("mr_count", rx_count, 3'd0);
        chk("mr_data", rx_data, 8'h00);
      end
    join
    repeat (BIT) @(negedge clk);
    chk("mr_hold_busy", busy, 1'b0);
    chk("mr_hold_count", rx_count, 3'd0);
    reset = 1'b0;
    idle_bits(1);
    send_char(8'h42, 8, 1'b1, 1);
    idle_bits(1);
    chk("mr_rx_count", rx_count, 3'd1);
    chk("mr_rx_data", rx_data, 8'h42);
    chk("mr_ferr", framing_err, 1'b0);
    pop();
    chk("mr_empty", rx_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
